// File: rtl/mux_arbiter_pkg.sv
// Shared constants for mux_arbiter: FSM encoding, requester count, index width
// and the rotating-priority search helper.
package mux_arbiter_pkg;

   localparam int REQ_N = 4;
   localparam int IDX_W = 2;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // First set bit of req, searching from ptr+1 upward with wrap-around;
   // ptr itself is examined last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [REQ_N-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 1; k <= REQ_N; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [REQ_N-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = REQ_N'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// Legacy 4-to-1 multiplexer, widened to W bits; {S1,S0} selects A0..A3.
module FourToOneMultiplexer #(
   parameter int W = 8
) (
   input  logic [W-1:0] A0,
   input  logic [W-1:0] A1,
   input  logic [W-1:0] A2,
   input  logic [W-1:0] A3,
   input  logic         S0,
   input  logic         S1,
   output logic [W-1:0] Y
);

   always_comb begin
      Y = A0;
      case ({S1, S0})
         2'b00:   Y = A0;
         2'b01:   Y = A1;
         2'b10:   Y = A2;
         default: Y = A3;
      endcase
   end

endmodule

// File: rtl/mux_arbiter.sv
// Four-requester rotating-priority arbiter driving a registered 4-to-1 data mux.
// Optional MUX_ARBITER_LOCK_EN adds a LOCK input that suppresses the MAX_HOLD timeout.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [REQ_N-1:0] REQ,
   input  logic [W-1:0]     A0,
   input  logic [W-1:0]     A1,
   input  logic [W-1:0]     A2,
   input  logic [W-1:0]     A3,
`ifdef MUX_ARBITER_LOCK_EN
   input  logic             LOCK,
`endif
   output logic [REQ_N-1:0] GNT,
   output logic             S0,
   output logic             S1,
   output logic [W-1:0]     Y,
   output logic             YV
);

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   logic [0:0]       state;
   logic [REQ_N-1:0] gnt;
   logic [IDX_W-1:0] sel;
   logic [IDX_W-1:0] ptr;
   logic [3:0]       hold;
   logic [W-1:0]     y;
   logic             yv;
   logic [W-1:0]     mux_y;

   logic             lock_hold;
   logic             timeout;
   logic [REQ_N-1:0] others;
   logic [REQ_N-1:0] pick_src;
   logic [IDX_W-1:0] pick_idx;

`ifdef MUX_ARBITER_LOCK_EN
   assign lock_hold = LOCK;
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      timeout  = (hold == HOLD_MAX) && !lock_hold;
      others   = REQ & ~gnt;
      pick_src = (state == IDLE) ? REQ : others;
      // The current owner is searched last, so excluding it changes nothing
      // except preventing a self-win when another requester is waiting.
      pick_idx = rr_pick(pick_src, ptr);
   end

   FourToOneMultiplexer #(
      .W (W)
   ) u_mux (
      .A0 (A0),
      .A1 (A1),
      .A2 (A2),
      .A3 (A3),
      .S0 (sel[0]),
      .S1 (sel[1]),
      .Y  (mux_y)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '1;
         hold  <= '0;
         y     <= '0;
         yv    <= 1'b0;
      end else begin
         y  <= mux_y;
         yv <= |gnt;
         if (state == IDLE) begin
            if (|REQ) begin
               state <= GRANT;
               gnt   <= onehot(pick_idx);
               sel   <= pick_idx;
               ptr   <= pick_idx;
               hold  <= 4'd1;
            end
         end else begin
            if (REQ[sel] && !timeout) begin
               hold <= (hold < HOLD_MAX) ? hold + 4'd1 : hold;
            end else if (|others) begin
               gnt  <= onehot(pick_idx);
               sel  <= pick_idx;
               ptr  <= pick_idx;
               hold <= 4'd1;
            end else if (REQ[sel]) begin
               hold <= 4'd1;
            end else begin
               state <= IDLE;
               gnt   <= '0;
               hold  <= '0;
            end
         end
      end
   end

   assign GNT = gnt;
   assign S0  = sel[0];
   assign S1  = sel[1];
   assign Y   = y;
   assign YV  = yv;

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized bench for mux_arbiter against a behavioural arbitration model;
// also exercises the LOCK input when MUX_ARBITER_LOCK_EN is defined.
module tb_mux_arbiter;

   localparam int W        = 8;
   localparam int MAX_HOLD = 4;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic [3:0]   REQ;
   logic [W-1:0] A0, A1, A2, A3;
`ifdef MUX_ARBITER_LOCK_EN
   logic         LOCK;
`endif
   logic [3:0]   GNT;
   logic         S0, S1;
   logic [W-1:0] Y;
   logic         YV;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: owner index or -1 when idle
   int           m_owner;
   int           m_hold;
   int           m_ptr;
   int           m_sel;
   logic [W-1:0] m_y;
   logic         m_yv;

   always #5 CLK = ~CLK;

   mux_arbiter #(
      .W        (W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .REQ   (REQ),
      .A0    (A0),
      .A1    (A1),
      .A2    (A2),
      .A3    (A3),
`ifdef MUX_ARBITER_LOCK_EN
      .LOCK  (LOCK),
`endif
      .GNT   (GNT),
      .S0    (S0),
      .S1    (S1),
      .Y     (Y),
      .YV    (YV)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_tests++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int next_owner(input logic [3:0] req, input int ptr);
      for (int k = 1; k <= 4; k++)
         if (req[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_step(input logic rst_n, input logic [3:0] req,
                             input logic [W-1:0] d [4], input logic lock);
      logic [3:0] rest;
      bit         stays;
      if (!rst_n) begin
         m_owner = -1; m_hold = 0; m_ptr = 3; m_sel = 0; m_y = '0; m_yv = 1'b0;
         return;
      end
      m_y  = d[m_sel];
      m_yv = (m_owner >= 0);
      if (m_owner < 0) begin
         if (req != 4'b0) begin
            m_owner = next_owner(req, m_ptr);
            m_hold  = 1;
         end
      end else begin
         stays = req[m_owner] && (m_hold < MAX_HOLD || lock);
         if (stays) begin
            if (m_hold < MAX_HOLD) m_hold++;
         end else begin
            rest = req;
            rest[m_owner] = 1'b0;
            if (rest != 4'b0) begin
               m_owner = next_owner(rest, m_ptr);
               m_hold  = 1;
            end else if (req[m_owner]) begin
               m_hold = 1;
            end else begin
               m_owner = -1;
               m_hold  = 0;
            end
         end
      end
      if (m_owner >= 0) begin
         m_ptr = m_owner;
         m_sel = m_owner;
      end
   endtask

   task automatic cycle(input logic rst_n, input logic [3:0] req,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [W-1:0] d3,
                        input logic lock);
      logic [W-1:0] d [4];
      logic [3:0]   exp_gnt;
      logic         eff_lock;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
`ifdef MUX_ARBITER_LOCK_EN
      eff_lock = lock;
`else
      eff_lock = 1'b0;
`endif
      @(negedge CLK);
      RST_N = rst_n; REQ = req; A0 = d0; A1 = d1; A2 = d2; A3 = d3;
`ifdef MUX_ARBITER_LOCK_EN
      LOCK = lock;
`endif
      model_step(rst_n, req, d, eff_lock);
      @(posedge CLK);
      #1;
      exp_gnt = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
      check("gnt", 32'(GNT), 32'(exp_gnt));
      check("sel", 32'({S1, S0}), 32'(m_sel));
      check("y",   32'(Y), 32'(m_y));
      check("yv",  32'(YV), 32'(m_yv));
   endtask

   initial begin
      logic [3:0] rq;
      logic       lk;
      RST_N = 1'b0; REQ = '0; A0 = '0; A1 = '0; A2 = '0; A3 = '0;
`ifdef MUX_ARBITER_LOCK_EN
      LOCK = 1'b0;
`endif
      m_owner = -1; m_hold = 0; m_ptr = 3; m_sel = 0; m_y = '0; m_yv = 1'b0;

      // single requester: timeout re-grant with no gap
      cycle(0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 0);
      check("rst_gnt", 32'(GNT), 32'h0);
      check("rst_yv",  32'(YV),  32'h0);
      for (int i = 0; i < 10; i++) cycle(1, 4'b0001, 8'd14, 8'd0, 8'd0, 8'd0, 0);
      check("solo_gnt", 32'(GNT), 32'h1);
      check("solo_y",   32'(Y),   32'd14);

      // all requesting: rotation 0,1,2,3,0
      cycle(0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 0);
      for (int i = 0; i < 22; i++) cycle(1, 4'b1111, 8'd14, 8'd8, 8'd4, 8'd9, 0);

      // owner 1 drops after 2 cycles -> requester 2, then reset mid-grant
      cycle(0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 0);
      for (int i = 0; i < 2; i++) cycle(1, 4'b0110, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      cycle(1, 4'b0100, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      check("drop_gnt", 32'(GNT), 32'h4);
      cycle(1, 4'b0100, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      check("drop_y", 32'(Y), 32'd4);
      cycle(0, 4'b1111, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      check("midrst_gnt", 32'(GNT), 32'h0);
      cycle(1, 4'b1111, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      check("after_rst_owner", 32'(GNT), 32'h1);

`ifdef MUX_ARBITER_LOCK_EN
      cycle(0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 4'b1001, 8'd14, 8'd8, 8'd4, 8'd9, 1);
      check("lock_gnt", 32'(GNT), 32'h1);
      cycle(1, 4'b1001, 8'd14, 8'd8, 8'd4, 8'd9, 0);
      check("unlock_gnt", 32'(GNT), 32'h8);
`endif

      // randomized traffic with sticky requests, occasional reset and lock
      rq = 4'b0000;
      lk = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3, 0) == 0) rq = 4'($urandom_range(15, 0));
         if ($urandom_range(7, 0) == 0) lk = ~lk;
         cycle(($urandom_range(63, 0) != 0), rq,
               8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), lk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
